// File: rtl/flag_unit_if.sv
// Bundle of ALU-flag, branch-request and branch-outcome signals for flag_unit.
// The master side drives requests; the slave side (flag_unit) returns flags and outcomes.
interface flag_unit_if;
    logic [2:0] alu_flags;
    logic [2:0] alu_op;
    logic       alu_valid;
    logic       stall;
    logic       branch_req;
    logic [2:0] cond;
    logic [2:0] flags_q;
    logic       branch_valid;
    logic       branch_taken;

    modport master (
        output alu_flags,
        output alu_op,
        output alu_valid,
        output stall,
        output branch_req,
        output cond,
        input  flags_q,
        input  branch_valid,
        input  branch_taken
    );

    modport slave (
        input  alu_flags,
        input  alu_op,
        input  alu_valid,
        input  stall,
        input  branch_req,
        input  cond,
        output flags_q,
        output branch_valid,
        output branch_taken
    );
endinterface

// File: rtl/flag_unit.sv
// Architectural {Z,V,N} flag register with per-opcode write masks and a registered branch
// evaluator. Define FLAG_BYPASS_EN to let a branch see the same-cycle flag update.
module flag_unit (
    input logic        clk,
    input logic        rst_n,
    flag_unit_if.slave bus
);

    typedef enum logic [2:0] {
        OpAdd    = 3'b000,
        OpSub    = 3'b001,
        OpXor    = 3'b010,
        OpRed    = 3'b011,
        OpSll    = 3'b100,
        OpSra    = 3'b101,
        OpRor    = 3'b110,
        OpPadsub = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        CcNe     = 3'b000,
        CcEq     = 3'b001,
        CcGt     = 3'b010,
        CcLt     = 3'b011,
        CcGe     = 3'b100,
        CcLe     = 3'b101,
        CcOv     = 3'b110,
        CcUncond = 3'b111
    } cond_e;

    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagN = 0;

    logic [2:0] flag_q, flag_d;
    logic       valid_q, valid_d;
    logic       taken_q, taken_d;

    logic [2:0] wr_mask;
    logic [2:0] post_flags;
    logic [2:0] eval_flags;
    logic       cond_hit;

    always_comb begin
        wr_mask = 3'b000;
        unique case (alu_op_e'(bus.alu_op))
            OpAdd, OpSub:               wr_mask = 3'b111;
            OpXor, OpSll, OpSra, OpRor: wr_mask = 3'b100;
            OpRed, OpPadsub:            wr_mask = 3'b000;
            default:                    wr_mask = 3'b000;
        endcase
    end

    // Unmasked bits pass through from the register untouched.
    always_comb begin
        post_flags = flag_q;
        if (bus.alu_valid) begin
            post_flags = (flag_q & ~wr_mask) | (bus.alu_flags & wr_mask);
        end
    end

`ifdef FLAG_BYPASS_EN
    assign eval_flags = post_flags;
`else
    assign eval_flags = flag_q;
`endif

    always_comb begin
        cond_hit = 1'b0;
        unique case (cond_e'(bus.cond))
            CcNe:     cond_hit = ~eval_flags[FlagZ];
            CcEq:     cond_hit = eval_flags[FlagZ];
            CcGt:     cond_hit = ~eval_flags[FlagZ] & ~eval_flags[FlagN];
            CcLt:     cond_hit = eval_flags[FlagN];
            CcGe:     cond_hit = eval_flags[FlagZ] | ~eval_flags[FlagN];
            CcLe:     cond_hit = eval_flags[FlagZ] | eval_flags[FlagN];
            CcOv:     cond_hit = eval_flags[FlagV];
            CcUncond: cond_hit = 1'b1;
            default:  cond_hit = 1'b0;
        endcase
    end

    // A stall freezes everything, including a branch_valid pulse already on the output.
    always_comb begin
        flag_d  = flag_q;
        valid_d = valid_q;
        taken_d = taken_q;
        if (!bus.stall) begin
            flag_d  = post_flags;
            valid_d = bus.branch_req;
            if (bus.branch_req) begin
                taken_d = cond_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q  <= 3'b000;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
        end
    end

    assign bus.flags_q      = flag_q;
    assign bus.branch_valid = valid_q;
    assign bus.branch_taken = taken_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed vector table plus randomized run against a rule-level model of flag_unit.
// Honours FLAG_BYPASS_EN for the expected branch flag source.
module tb_flag_unit;

    logic clk;
    logic rst_n;
    flag_unit_if bus ();

    flag_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

`ifdef FLAG_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        logic       rst_n;
        logic       alu_valid;
        logic [2:0] alu_op;
        logic [2:0] alu_flags;
        logic       stall;
        logic       branch_req;
        logic [2:0] cond;
        logic [2:0] exp_flags;
        logic       exp_valid;
        logic       exp_taken;
    } vec_t;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [2:0] op,
                         input logic [2:0] af, input logic st, input logic br,
                         input logic [2:0] c);
        rst_n          = r;
        bus.alu_valid  = av;
        bus.alu_op     = op;
        bus.alu_flags  = af;
        bus.stall      = st;
        bus.branch_req = br;
        bus.cond       = c;
    endtask

    // Flags after an ALU result, written from the opcode's stated flag effects.
    function automatic logic [2:0] model_update(input logic [2:0] f, input logic av,
                                                input logic [2:0] op, input logic [2:0] af);
        logic z, v, n;
        {z, v, n} = f;
        if (av) begin
            if (op == 3'd0 || op == 3'd1) begin
                {z, v, n} = af;
            end else if (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) begin
                z = af[2];
            end
        end
        return {z, v, n};
    endfunction

    function automatic logic model_cond(input logic [2:0] f, input logic [2:0] c);
        logic z, v, n;
        {z, v, n} = f;
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    vec_t vecs[21];

    logic [2:0] m_flags;
    logic       m_valid;
    logic       m_taken;

    initial begin
        checks   = 0;
        failures = 0;

        //          rst  av  op     af      st  br  cond    flags   v  taken
        vecs[0]  = '{1'b0, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0};
        vecs[1]  = '{1'b1, 1, 3'd0, 3'b101, 0, 0, 3'd0, 3'b101, 0, 0};
        vecs[2]  = '{1'b1, 1, 3'd2, 3'b010, 0, 0, 3'd0, 3'b001, 0, 0};
        vecs[3]  = '{1'b1, 1, 3'd3, 3'b111, 0, 0, 3'd0, 3'b001, 0, 0};
        vecs[4]  = '{1'b0, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0};
        vecs[5]  = '{1'b1, 1, 3'd1, 3'b100, 0, 1, 3'd1, 3'b100, 1, Bypass};
        vecs[6]  = '{1'b1, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b100, 0, 0};
        vecs[7]  = '{1'b0, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0};
        vecs[8]  = '{1'b1, 1, 3'd0, 3'b010, 0, 0, 3'd0, 3'b010, 0, 0};
        vecs[9]  = '{1'b1, 0, 3'd0, 3'b000, 0, 1, 3'd6, 3'b010, 1, 1};
        vecs[10] = '{1'b1, 0, 3'd0, 3'b000, 0, 1, 3'd2, 3'b010, 1, 1};
        vecs[11] = '{1'b1, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b010, 0, 0};
        vecs[12] = '{1'b1, 1, 3'd0, 3'b111, 1, 1, 3'd7, 3'b010, 0, 0};
        vecs[13] = '{1'b1, 1, 3'd0, 3'b111, 1, 1, 3'd7, 3'b010, 0, 0};
        vecs[14] = '{1'b1, 1, 3'd0, 3'b111, 1, 1, 3'd7, 3'b010, 0, 0};
        vecs[15] = '{1'b1, 0, 3'd0, 3'b000, 0, 1, 3'd7, 3'b010, 1, 1};
        vecs[16] = '{1'b1, 1, 3'd0, 3'b111, 0, 1, 3'd0, 3'b111, 1, !Bypass};
        vecs[17] = '{1'b0, 1, 3'd0, 3'b010, 1, 1, 3'd7, 3'b000, 0, 0};
        vecs[18] = '{1'b1, 0, 3'd0, 3'b000, 0, 1, 3'd0, 3'b000, 1, 1};
        vecs[19] = '{1'b1, 0, 3'd0, 3'b000, 1, 0, 3'd0, 3'b000, 1, 1};
        vecs[20] = '{1'b1, 0, 3'd0, 3'b000, 0, 0, 3'd0, 3'b000, 0, 0};

        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst_n, vecs[i].alu_valid, vecs[i].alu_op, vecs[i].alu_flags,
                  vecs[i].stall, vecs[i].branch_req, vecs[i].cond);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d flags_q", i), bus.flags_q, vecs[i].exp_flags);
            check($sformatf("vec%0d branch_valid", i), {2'b00, bus.branch_valid},
                  {2'b00, vecs[i].exp_valid});
            if (vecs[i].exp_valid || !vecs[i].rst_n) begin
                check($sformatf("vec%0d branch_taken", i), {2'b00, bus.branch_taken},
                      {2'b00, vecs[i].exp_taken});
            end
        end

        // Randomized run: start from a known reset, then track the model each cycle.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        m_flags = 3'b000;
        m_valid = 1'b0;
        m_taken = 1'b0;
        for (int i = 0; i < 500; i++) begin
            logic       r, av, st, br;
            logic [2:0] op, af, c, post;
            r  = ($urandom_range(0, 99) >= 3);
            av = $urandom_range(0, 1);
            st = ($urandom_range(0, 3) == 0);
            br = $urandom_range(0, 1);
            op = 3'($urandom_range(0, 7));
            af = 3'($urandom_range(0, 7));
            c  = 3'($urandom_range(0, 7));
            drive(r, av, op, af, st, br, c);

            post = model_update(m_flags, av, op, af);
            if (!r) begin
                m_flags = 3'b000;
                m_valid = 1'b0;
                m_taken = 1'b0;
            end else if (!st) begin
                if (br) m_taken = model_cond(Bypass ? post : m_flags, c);
                m_valid = br;
                m_flags = post;
            end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d flags_q", i), bus.flags_q, m_flags);
            check($sformatf("rnd%0d branch_valid", i), {2'b00, bus.branch_valid},
                  {2'b00, m_valid});
            if (m_valid) begin
                check($sformatf("rnd%0d branch_taken", i), {2'b00, bus.branch_taken},
                      {2'b00, m_taken});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
